// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and its datapath.
// start is a level request; opcode/funct3/zero are sampled by the sequencer.
interface multicycle_ctrl_if;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;

  logic        irWrite;
  logic        pcWrite;
  logic [1:0]  pcSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic [1:0]  memtoReg;

  logic [3:0]  state;
  logic        busy;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] instret;

  modport ctrl (
    input  start, opcode, funct3, zero,
    output irWrite, pcWrite, pcSrc, ALUSrcA, ALUSrcB, ALUOp,
           memRead, memWrite, regWrite, memtoReg,
           state, busy, halted, cycle_count, instret
  );

  modport dp (
    output start, opcode, funct3, zero,
    input  irWrite, pcWrite, pcSrc, ALUSrcA, ALUSrcB, ALUOp,
           memRead, memWrite, regWrite, memtoReg,
           state, busy, halted, cycle_count, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle RV32I-subset CPU: steps one instruction
// through fetch/decode/execute/memory/write-back, with cycle and retire counters.
module multicycle_ctrl #(
  parameter int unsigned MAX_INSTR = 0
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.ctrl   bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_R    = 4'd3;
  localparam logic [3:0] S_EXEC_I    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_READ  = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_ALU_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_HALT      = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] BUDGET = 32'(MAX_INSTR);

  logic [3:0]  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [31:0] cycle_count_q, instret_q;
  logic        busy, retiring, budget_hit;

  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign retiring   = (state_q == S_ALU_WB) || (state_q == S_MEM_WB) ||
                      (state_q == S_MEM_WRITE) || (state_q == S_BRANCH) ||
                      (state_q == S_JUMP);
  assign budget_hit = (BUDGET != 32'd0) && ((instret_q + 32'd1) == BUDGET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    case (state_q)
      S_IDLE:     if (bus.start) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        // Load/store share MEM_ADDR; remember which one for the next hop.
        is_load_d = (bus.opcode == OP_LOAD);
        case (bus.opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JUMP;
          default:            state_d = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = is_load_q ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP:
                  state_d = budget_hit ? S_HALT : S_FETCH;
      default:    state_d = S_HALT;
    endcase
  end

  always_comb begin
    bus.irWrite  = 1'b0;
    bus.pcWrite  = 1'b0;
    bus.pcSrc    = 2'b00;
    bus.ALUSrcA  = 2'b00;
    bus.ALUSrcB  = 2'b00;
    bus.ALUOp    = 2'b00;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.regWrite = 1'b0;
    bus.memtoReg = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.irWrite = 1'b1;
        bus.pcWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 2'b11;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b10;
      end
      S_MEM_READ:  bus.memRead = 1'b1;
      S_MEM_WB: begin
        bus.regWrite = 1'b1;
        bus.memtoReg = 2'b01;
      end
      S_MEM_WRITE: bus.memWrite = 1'b1;
      S_ALU_WB:    bus.regWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.pcSrc   = 2'b01;
        // beq takes on zero, bne on !zero; other funct3 never take.
        bus.pcWrite = ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001)) &&
                      (bus.zero ^ bus.funct3[0]);
      end
      S_JUMP: begin
        bus.regWrite = 1'b1;
        bus.memtoReg = 2'b10;
        bus.pcWrite  = 1'b1;
        bus.pcSrc    = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_q <= 32'd0;
      instret_q     <= 32'd0;
    end else begin
      if (busy)     cycle_count_q <= cycle_count_q + 32'd1;
      if (retiring) instret_q     <= instret_q + 32'd1;
    end
  end

  assign bus.state       = state_q;
  assign bus.busy        = busy;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.cycle_count = cycle_count_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + random bench for multicycle_ctrl: expected control vectors are
// queued per instruction and compared each cycle on the falling edge.
module tb_multicycle_ctrl;

  localparam int W = 21;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  logic clk;
  logic rst;

  multicycle_ctrl_if bus_a ();
  multicycle_ctrl_if bus_b ();

  multicycle_ctrl #(.MAX_INSTR(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  multicycle_ctrl #(.MAX_INSTR(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           vectors;
  int           miscompares;
  logic [31:0]  exp_cc;
  logic [31:0]  exp_ir;

  // Reference control word for a state, straight from the state table.
  function automatic logic [W-1:0] ref_vec(input logic [3:0] st, input logic taken);
    logic       ir, pw, mr, mw, rw, bz, hl;
    logic [1:0] ps, sa, sb, op, mt;
    ir = 0; pw = 0; mr = 0; mw = 0; rw = 0;
    ps = 0; sa = 0; sb = 0; op = 0; mt = 0;
    case (st)
      4'd1:  begin ir = 1; pw = 1; sb = 2'b01; end
      4'd2:  begin sa = 2'b01; sb = 2'b10; end
      4'd3:  begin sa = 2'b10; op = 2'b10; end
      4'd4:  begin sa = 2'b10; sb = 2'b10; op = 2'b11; end
      4'd5:  begin sa = 2'b10; sb = 2'b10; end
      4'd6:  mr = 1;
      4'd7:  begin rw = 1; mt = 2'b01; end
      4'd8:  mw = 1;
      4'd9:  rw = 1;
      4'd10: begin sa = 2'b10; op = 2'b01; ps = 2'b01; pw = taken; end
      4'd11: begin rw = 1; mt = 2'b10; pw = 1; ps = 2'b01; end
      default: ;
    endcase
    bz = (st != 4'd0) && (st != 4'd15);
    hl = (st == 4'd15);
    return {st, ir, pw, ps, sa, sb, op, mr, mw, rw, mt, bz, hl};
  endfunction

  function automatic logic [W-1:0] obs_vec(input int sel);
    if (sel == 0)
      return {bus_a.state, bus_a.irWrite, bus_a.pcWrite, bus_a.pcSrc, bus_a.ALUSrcA,
              bus_a.ALUSrcB, bus_a.ALUOp, bus_a.memRead, bus_a.memWrite, bus_a.regWrite,
              bus_a.memtoReg, bus_a.busy, bus_a.halted};
    else
      return {bus_b.state, bus_b.irWrite, bus_b.pcWrite, bus_b.pcSrc, bus_b.ALUSrcA,
              bus_b.ALUSrcB, bus_b.ALUOp, bus_b.memRead, bus_b.memWrite, bus_b.regWrite,
              bus_b.memtoReg, bus_b.busy, bus_b.halted};
  endfunction

  function automatic logic [31:0] obs_cc(input int sel);
    return (sel == 0) ? bus_a.cycle_count : bus_b.cycle_count;
  endfunction

  function automatic logic [31:0] obs_ir(input int sel);
    return (sel == 0) ? bus_a.instret : bus_b.instret;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic [6:0] op, input logic [2:0] f3, input logic z);
    if (sel == 0) begin
      bus_a.opcode = op; bus_a.funct3 = f3; bus_a.zero = z;
    end else begin
      bus_b.opcode = op; bus_b.funct3 = f3; bus_b.zero = z;
    end
  endtask

  task automatic set_start(input int sel, input logic s);
    if (sel == 0) bus_a.start = s;
    else          bus_b.start = s;
  endtask

  task automatic expect_state(input logic [3:0] st, input logic taken);
    exp_q.push_back(ref_vec(st, taken));
  endtask

  // Advance one cycle, pop the next expected word and compare it plus counters.
  task automatic step(input int sel, input string tag);
    logic [W-1:0] e, o;
    logic [3:0]   est;
    @(negedge clk);
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs_vec(sel));
    end else begin
      e   = exp_q.pop_front();
      o   = obs_vec(sel);
      est = e[W-1 -: 4];
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s ctrl observed=%h expected=%h (state %0d)", tag, o, e, est);
      end
      check_val({tag, "_cycles"}, obs_cc(sel), exp_cc);
      check_val({tag, "_instret"}, obs_ir(sel), exp_ir);
      if (est != 4'd0 && est != 4'd15) exp_cc = exp_cc + 32'd1;
      if (est inside {4'd7, 4'd8, 4'd9, 4'd10, 4'd11}) exp_ir = exp_ir + 32'd1;
    end
  endtask

  task automatic run(input int sel, input int kind, input logic [2:0] f3,
                     input logic z, input string tag);
    logic taken;
    int   n;
    taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
    n = 0;
    case (kind)
      K_R:   begin drive(sel, 7'b0110011, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(3, 0); expect_state(9, 0); n = 4; end
      K_I:   begin drive(sel, 7'b0010011, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(4, 0); expect_state(9, 0); n = 4; end
      K_LW:  begin drive(sel, 7'b0000011, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(5, 0); expect_state(6, 0);
                   expect_state(7, 0); n = 5; end
      K_SW:  begin drive(sel, 7'b0100011, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(5, 0); expect_state(8, 0); n = 4; end
      K_BR:  begin drive(sel, 7'b1100011, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(10, taken); n = 3; end
      K_JAL: begin drive(sel, 7'b1101111, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(11, 0); n = 3; end
      default: begin drive(sel, 7'b1111111, f3, z);
                   expect_state(1, 0); expect_state(2, 0); expect_state(15, 0); n = 3; end
    endcase
    for (int i = 0; i < n; i++) step(sel, tag);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_cc = 32'd0;
    exp_ir = 32'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_model();
    rst = 1'b0;
    bus_a.start = 0; bus_b.start = 0;
    drive(0, 7'd0, 3'd0, 1'b0);
    drive(1, 7'd0, 3'd0, 1'b0);

    // Reset state on both instances, with start held high on A during reset.
    bus_a.start = 1;
    expect_state(0, 0); step(0, "reset_a");
    expect_state(0, 0); step(1, "reset_b");
    bus_a.start = 0;
    rst = 1'b1;
    expect_state(0, 0); step(0, "idle_hold");

    // R-type from IDLE, then start dropped and execution continues.
    bus_a.start = 1;
    run(0, K_R, 3'd0, 1'b0, "r_type");
    bus_a.start = 0;
    @(posedge clk); #1;
    check_val("r_type_cc4", bus_a.cycle_count, 32'd4);
    check_val("r_type_ir1", bus_a.instret, 32'd1);

    run(0, K_I,   3'd0, 1'b0, "i_type");
    run(0, K_LW,  3'd2, 1'b0, "lw");
    run(0, K_SW,  3'd2, 1'b1, "sw");
    run(0, K_BR,  3'b000, 1'b1, "beq_taken");
    run(0, K_BR,  3'b001, 1'b1, "bne_not_taken");
    run(0, K_BR,  3'b001, 1'b0, "bne_taken");
    run(0, K_BR,  3'b000, 1'b0, "beq_not_taken");
    run(0, K_BR,  3'b100, 1'b1, "br_other_f3");
    run(0, K_JAL, 3'd0, 1'b0, "jal");

    for (int i = 0; i < 12; i++) begin
      run(0, int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), "random");
    end

    // Illegal opcode halts; start toggling does not leave HALT.
    run(0, K_ILL, 3'd0, 1'b0, "illegal");
    for (int i = 0; i < 4; i++) begin
      bus_a.start = ~bus_a.start;
      expect_state(15, 0);
      step(0, "halt_sticky");
    end

    // Budget of 3 on instance B: three addi then HALT.
    clear_model();
    bus_b.start = 1;
    run(1, K_I, 3'd0, 1'b0, "budget_1");
    bus_b.start = 0;
    run(1, K_I, 3'd0, 1'b0, "budget_2");
    run(1, K_I, 3'd0, 1'b0, "budget_3");
    expect_state(15, 0); step(1, "budget_halt");
    check_val("budget_cc12", bus_b.cycle_count, 32'd12);
    check_val("budget_ir3", bus_b.instret, 32'd3);
    bus_b.start = 1;
    expect_state(15, 0); step(1, "budget_halt_hold");

    // Reset abort in MEM_READ on A.
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    bus_a.start = 1;
    drive(0, 7'b0000011, 3'd2, 1'b0);
    expect_state(1, 0); expect_state(2, 0); expect_state(5, 0); expect_state(6, 0);
    for (int i = 0; i < 4; i++) step(0, "lw_abort");
    bus_a.start = 0;
    rst = 1'b0;
    #1;
    vectors++;
    assert (obs_vec(0) === ref_vec(4'd0, 1'b0)) else begin
      miscompares++;
      $error("FAIL abort_ctrl observed=%h expected=%h", obs_vec(0), ref_vec(4'd0, 1'b0));
    end
    check_val("abort_cc", bus_a.cycle_count, 32'd0);
    check_val("abort_ir", bus_a.instret, 32'd0);
    clear_model();
    expect_state(0, 0); step(0, "abort_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control sequencer for the multi-cycle variant of the RV32I-subset CPU. It replaces the single-cycle `Control` decoder and per-cycle PC update with a state machine. That state machine steps one instruction through fetch, decode, execute, memory and write-back over 3–5 clocks, using the same `PC`, `Register`, `ALU`, `ALUCtrl` and `DataMemory` instances. It also keeps cycle and retired-instruction counters and halts on an illegal opcode or an instruction budget.

## Interface
- `MAX_INSTR`, default 0: retired-instruction budget. 0 means unlimited; otherwise the block halts after retiring this many instructions.
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous reset, active-low
- `start`  in  1  level; sampled only in IDLE
- `opcode`  in  7  inst[6:0] from instruction register; used in DECODE
- `funct3`  in  3  inst[14:12] from IR; used in BRANCH
- `zero`  in  1  ALU zero flag; used in BRANCH
- `irWrite`  out  1  latch instruction register (and oldPC)
- `pcWrite`  out  1  PC register load enable
- `pcSrc`  out  2  00 ALU result, 01 ALUOut register (target)
- `ALUSrcA`  out  2  00 PC, 01 oldPC, 10 rs1
- `ALUSrcB`  out  2  00 rs2, 01 constant 4, 10 imm
- `ALUOp`  out  2  00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
- `memRead`  out  1  data memory read
- `memWrite`  out  1  data memory write
- `regWrite`  out  1  register file write
- `memtoReg`  out  2  00 ALUOut, 01 MDR, 10 PC (already oldPC+4)
- `state`  out  4  current state code
- `busy`  out  1  high in every state except IDLE and HALT
- `halted`  out  1  high in HALT
- `cycle_count`  out  32  clocks spent while busy
- `instret`  out  32  retired instructions

## Operation
- **State codes:** IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8, ALU_WB 9, BRANCH 10, JUMP 11, HALT 15. Codes 12–14 are unreachable and fall to HALT.
- **Transitions:**
  - IDLE→FETCH when start=1.
  - FETCH→DECODE always.
  - DECODE dispatches on opcode:
    - 0110011→EXEC_R
    - 0010011→EXEC_I
    - 0000011 and 0100011→MEM_ADDR
    - 1100011→BRANCH
    - 1101111→JUMP
    - any other→HALT
  - EXEC_R and EXEC_I→ALU_WB.
  - MEM_ADDR→MEM_READ for load, MEM_WRITE for store; the class is remembered in a 1-bit flag latched in DECODE.
  - MEM_READ→MEM_WB.
  - Retiring states (ALU_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP)→FETCH, or →HALT if MAX_INSTR≠0 and instret+1==MAX_INSTR.
  - HALT is sticky until reset.
- **Outputs** are combinational from state only (pcWrite in BRANCH also depends on zero and funct3). Any signal not listed for a state is 0.
  - FETCH: irWrite=1, pcWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00, pcSrc=00.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00. This precomputes the branch/jump target into ALUOut.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=11.
  - MEM_ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=00.
  - MEM_READ: memRead=1.
  - MEM_WB: regWrite=1, memtoReg=01.
  - MEM_WRITE: memWrite=1.
  - ALU_WB: regWrite=1, memtoReg=00.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, pcSrc=01, pcWrite=(zero XOR funct3[0]) for beq/bne. funct3 values other than 000/001 are treated as not taken.
  - JUMP: regWrite=1, memtoReg=10, pcWrite=1, pcSrc=01.
- **Counters:**
  - cycle_count increments on every clock edge where the pre-edge state is busy.
  - instret increments on the edge leaving a retiring state.
  - Both are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
  - An illegal opcode never increments instret.

## Timing
- **Reset:** rst=0 immediately forces state=IDLE; all control outputs, busy, halted and the counters go to 0. This holds even mid-instruction, and no partial write completes after reset assertion.
- **Reset release:** the first edge after rst rises may take IDLE→FETCH if start=1.
- **Latency:** R/I-ALU, sw and jal take 4, 4 and 3 cycles; lw takes 5; beq/bne take 3. Counting is from entering FETCH to re-entering FETCH.
- **start:** deassertion after leaving IDLE is ignored, and execution continues. start has no effect in HALT.
- **Single-cycle strobes:** regWrite and memWrite are high for exactly one cycle per instruction.
- **Halt:** halted rises one cycle after DECODE of an illegal opcode, or one cycle after the final retiring state under the budget.

## Test plan
- **Reset/start:** reset, then start=1 → next edge state=1, irWrite=1, pcWrite=1, ALUSrcB=01; busy=1.
- **R-type:** opcode 0110011 → states 1,2,3,9,1. regWrite is high only in state 9. instret goes 0→1 and cycle_count goes 0→4.
- **Load/store:** lw (0000011) → states 1,2,5,6,7, with memRead only in 6 and regWrite with memtoReg=01 only in 7. sw (0100011) → 1,2,5,8, with memWrite one cycle and regWrite never.
- **Branch:** beq with funct3=000, zero=1 → pcWrite=1, pcSrc=01 in state 10. bne with funct3=001, zero=1 → pcWrite=0. Both re-enter FETCH after 3 cycles.
- **Illegal opcode:** opcode 1111111 → DECODE then HALT (state 15), halted=1, instret unchanged. Toggling start keeps HALT.
- **Budget and reset abort:** MAX_INSTR=3 with three addi (0010011) → halted after third ALU_WB, instret=3, cycle_count=12. Separately, asserting rst in MEM_READ → state 0 and all outputs and counters 0 before the next edge.
